// File: rtl/any1_wb_mem_responder.sv
// any1_wb_mem_responder
//   Bus responder for the any1oo 128-bit bus. One address window is backed
//   by a 128-bit RAM with per-byte write enables. The responder adds a
//   programmable number of wait states before ack. Accesses outside the
//   window, and writes when READONLY is set, get a one-cycle err_o.
//
// Ports
//   rst_i  : asynchronous active-high reset
//   clk_i  : clock
//   cyc_i  : bus cycle active
//   stb_i  : transfer strobe
//   we_i   : 1 = write
//   sel_i  : byte-lane enables; bit n covers dat bits [8n+7:8n]
//   adr_i  : byte address; bits [3:0] are ignored
//   dat_i  : write data
//   ack_o  : transfer complete, high for one cycle
//   err_o  : transfer error, high for one cycle
//   dat_o  : read data, valid only while ack_o is high, otherwise 0
//
// State | meaning
//   IDLE    | waiting for cyc_i & stb_i
//   WAIT    | counting wait states; dropping the strobe aborts the transfer
//   ACK     | ack_o high; read data is on dat_o
//   ERR     | err_o high
//   RELEASE | response given; wait for the strobe to drop
module any1_wb_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_E000,
  parameter int          DEPTH       = 512,
  parameter int          WAIT_STATES = 1,
  parameter bit          READONLY    = 1'b0
) (
  input  logic         rst_i,
  input  logic         clk_i,
  input  logic         cyc_i,
  input  logic         stb_i,
  input  logic         we_i,
  input  logic [15:0]  sel_i,
  input  logic [31:0]  adr_i,
  input  logic [127:0] dat_i,
  output logic         ack_o,
  output logic         err_o,
  output logic [127:0] dat_o
);

  localparam int AW = $clog2(DEPTH);
  // The counter starts at WAIT_STATES-1 because the IDLE->WAIT edge is
  // already the first wait cycle.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ACK     = 3'd2,
    S_ERR     = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   dat_q, dat_d;
  logic [127:0]   mem [DEPTH];

  logic           req;
  logic           hit;
  logic           commit;
  logic [AW-1:0]  idx;

  assign req = cyc_i & stb_i;
  assign hit = ((adr_i & ADDR_MASK) == ADDR_BASE);
  assign idx = adr_i[4 +: AW];

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
    end
  end

  // Next-state logic. commit marks the single edge that enters ACK; the
  // memory write and the read capture both happen on that edge only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (!hit || (we_i && READONLY)) begin
            state_d = S_ERR;
          end else if (WAIT_STATES == 0) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:     state_d = S_RELEASE;
      S_ERR:     state_d = S_RELEASE;
      S_RELEASE: if (!req) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // dat_o is only non-zero in the cycle after a read commit.
    dat_d = (commit && !we_i) ? mem[idx] : '0;
  end

  // Output logic
  always_comb begin
    ack_o = 1'b0;
    err_o = 1'b0;
    dat_o = dat_q;
    if (state_q == S_ACK) ack_o = 1'b1;
    if (state_q == S_ERR) err_o = 1'b1;
  end

  // Memory is not reset. Writes are gated by rst_i so that a transfer
  // cannot commit while reset is held.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && we_i && !READONLY) begin
      for (int n = 0; n < 16; n++) begin
        if (sel_i[n]) mem[idx][8*n +: 8] <= dat_i[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_any1_wb_mem_responder.sv
module tb_any1_wb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         we;
  logic [15:0]  sel;
  logic [31:0]  adr;
  logic [127:0] dat_w;
  logic cyc0, stb0, cyc3, stb3, cycr, stbr;
  logic ack0, err0, ack3, err3, ackr, errr;
  logic [127:0] do0, do3, dor;

  // default parameters: WAIT_STATES=1
  any1_wb_mem_responder u_ws1 (
    .rst_i(rst), .clk_i(clk), .cyc_i(cyc0), .stb_i(stb0), .we_i(we),
    .sel_i(sel), .adr_i(adr), .dat_i(dat_w),
    .ack_o(ack0), .err_o(err0), .dat_o(do0));

  any1_wb_mem_responder #(.WAIT_STATES(3)) u_ws3 (
    .rst_i(rst), .clk_i(clk), .cyc_i(cyc3), .stb_i(stb3), .we_i(we),
    .sel_i(sel), .adr_i(adr), .dat_i(dat_w),
    .ack_o(ack3), .err_o(err3), .dat_o(do3));

  any1_wb_mem_responder #(.WAIT_STATES(0), .READONLY(1'b1)) u_ro (
    .rst_i(rst), .clk_i(clk), .cyc_i(cycr), .stb_i(stbr), .we_i(we),
    .sel_i(sel), .adr_i(adr), .dat_i(dat_w),
    .ack_o(ackr), .err_o(errr), .dat_o(dor));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_req(input int w, input logic v);
    case (w)
      0:       begin cyc0 = v; stb0 = v; end
      3:       begin cyc3 = v; stb3 = v; end
      default: begin cycr = v; stbr = v; end
    endcase
  endtask

  task automatic get_rsp(input int w, output logic a, output logic e, output logic [127:0] d);
    case (w)
      0:       begin a = ack0; e = err0; d = do0; end
      3:       begin a = ack3; e = err3; d = do3; end
      default: begin a = ackr; e = errr; d = dor; end
    endcase
  endtask

  // Call at posedge+#1. lat is the number of edges from the strobe-sampling
  // edge to the first response (0 = no response within the budget).
  task automatic xfer(input int w, input logic iwe, input logic [31:0] iadr,
                      input logic [15:0] isel, input logic [127:0] idat, input int hold,
                      output int lat, output int nack, output int nerr,
                      output logic [127:0] rdata, output int nbad);
    logic a, e;
    logic [127:0] d;
    lat = 0; nack = 0; nerr = 0; rdata = '0; nbad = 0;
    we = iwe; adr = iadr; sel = isel; dat_w = idat;
    set_req(w, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      get_rsp(w, a, e, d);
      if (a) begin nack++; rdata = d; if (lat == 0) lat = c; end
      if (e) begin nerr++; if (lat == 0) lat = c; end
      if (!a && d !== '0) nbad++;
      if (a && e) nbad++;
      if (lat != 0 && c >= hold) break;
    end
    set_req(w, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      get_rsp(w, a, e, d);
      if (a) nack++;
      if (e) nerr++;
      if (d !== '0) nbad++;
    end
  endtask

  typedef struct {
    logic         we;
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
    logic         exp_err;
    logic [127:0] exp_data;
  } vec_t;

  function automatic vec_t mkv(input logic iwe, input logic [31:0] iadr, input logic [15:0] isel,
                               input logic [127:0] idat, input logic ierr, input logic [127:0] iexp);
    vec_t v;
    v.we = iwe; v.adr = iadr; v.sel = isel; v.dat = idat; v.exp_err = ierr; v.exp_data = iexp;
    return v;
  endfunction

  localparam logic [127:0] D_A   = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] D_B   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
  localparam logic [127:0] D_C   = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [127:0] ONES  = {128{1'b1}};
  localparam logic [127:0] PART  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000;
  localparam logic [127:0] A5S   = {16{8'hA5}};
  localparam logic [127:0] B11   = {16{8'h11}};
  localparam logic [127:0] B22   = {16{8'h22}};
  localparam logic [127:0] MIX   = 128'h2211_1111_1111_1111_1111_1111_1111_1122;

  vec_t vecs[18];

  initial begin
    int lat, nack, nerr, nbad;
    logic [127:0] rdata, ro_before;
    int n_abort_ack;

    vecs[0]  = mkv(1'b1, 32'h0000_0010, 16'hFFFF, D_A,   1'b0, '0);
    vecs[1]  = mkv(1'b0, 32'h0000_0010, 16'h0001, '0,    1'b0, D_A);
    vecs[2]  = mkv(1'b1, 32'h0000_0020, 16'hFFFF, ONES,  1'b0, '0);
    vecs[3]  = mkv(1'b1, 32'h0000_0020, 16'h000F, '0,    1'b0, '0);
    vecs[4]  = mkv(1'b0, 32'h0000_0020, 16'hFFFF, '0,    1'b0, PART);
    vecs[5]  = mkv(1'b1, 32'h0000_0020, 16'h0000, 128'h1234, 1'b0, '0);
    vecs[6]  = mkv(1'b0, 32'h0000_0020, 16'hFFFF, '0,    1'b0, PART);
    vecs[7]  = mkv(1'b1, 32'hFF00_0010, 16'hFFFF, '0,    1'b1, '0);
    vecs[8]  = mkv(1'b0, 32'hFF00_0000, 16'hFFFF, '0,    1'b1, '0);
    vecs[9]  = mkv(1'b1, 32'h0000_2000, 16'hFFFF, '0,    1'b1, '0);
    vecs[10] = mkv(1'b0, 32'h0000_0010, 16'hFFFF, '0,    1'b0, D_A);
    vecs[11] = mkv(1'b1, 32'h0000_1FF0, 16'hFFFF, A5S,   1'b0, '0);
    vecs[12] = mkv(1'b0, 32'h0000_1FF0, 16'hFFFF, '0,    1'b0, A5S);
    vecs[13] = mkv(1'b1, 32'h0000_0030, 16'hFFFF, B11,   1'b0, '0);
    vecs[14] = mkv(1'b1, 32'h0000_0030, 16'h8001, B22,   1'b0, '0);
    vecs[15] = mkv(1'b0, 32'h0000_0030, 16'hFFFF, '0,    1'b0, MIX);
    vecs[16] = mkv(1'b0, 32'h0000_2000, 16'hFFFF, '0,    1'b1, '0);
    vecs[17] = mkv(1'b0, 32'h0000_1FFF, 16'hFFFF, '0,    1'b0, A5S);

    we = 1'b0; sel = '0; adr = '0; dat_w = '0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; cycr = 1'b0; stbr = 1'b0;

    // Reset state
    #12;
    chk("reset_flags", {122'd0, ack0, err0, ack3, err3, ackr, errr}, '0);
    chk("reset_dat", do0 | do3 | dor, '0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors on the WAIT_STATES=1 instance
    foreach (vecs[i]) begin
      xfer(0, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, 1, lat, nack, nerr, rdata, nbad);
      chk_int($sformatf("v%0d_lat", i), lat, vecs[i].exp_err ? 1 : 2);
      chk_int($sformatf("v%0d_acks", i), nack, vecs[i].exp_err ? 0 : 1);
      chk_int($sformatf("v%0d_errs", i), nerr, vecs[i].exp_err ? 1 : 0);
      chk($sformatf("v%0d_data", i), rdata, vecs[i].exp_data);
      chk_int($sformatf("v%0d_bad", i), nbad, 0);
    end

    // Strobe held for 10 cycles: exactly one ack
    xfer(0, 1'b0, 32'h10, 16'hFFFF, '0, 10, lat, nack, nerr, rdata, nbad);
    chk_int("hold_acks", nack, 1);
    chk_int("hold_lat", lat, 2);
    chk("hold_data", rdata, D_A);
    chk_int("hold_bad", nbad, 0);

    // WAIT_STATES=3: normal write, then a write aborted in the 2nd wait cycle
    xfer(3, 1'b1, 32'h40, 16'hFFFF, D_B, 1, lat, nack, nerr, rdata, nbad);
    chk_int("ws3_wr_lat", lat, 4);
    chk_int("ws3_wr_acks", nack, 1);
    we = 1'b1; adr = 32'h40; sel = 16'hFFFF; dat_w = D_C;
    set_req(3, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc3 = 1'b0;
    n_abort_ack = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack3 || err3) n_abort_ack++;
    end
    stb3 = 1'b0;
    chk_int("abort_no_ack", n_abort_ack, 0);
    xfer(3, 1'b0, 32'h40, 16'hFFFF, '0, 1, lat, nack, nerr, rdata, nbad);
    chk_int("abort_rd_lat", lat, 4);
    chk("abort_rd_data", rdata, D_B);
    chk_int("abort_rd_bad", nbad, 0);

    // READONLY, zero wait states
    xfer(2, 1'b0, 32'h50, 16'hFFFF, '0, 1, lat, nack, nerr, ro_before, nbad);
    chk_int("ro_rd0_lat", lat, 1);
    chk_int("ro_rd0_acks", nack, 1);
    xfer(2, 1'b1, 32'h50, 16'hFFFF, D_A, 1, lat, nack, nerr, rdata, nbad);
    chk_int("ro_wr_lat", lat, 1);
    chk_int("ro_wr_errs", nerr, 1);
    chk_int("ro_wr_acks", nack, 0);
    xfer(2, 1'b0, 32'h50, 16'hFFFF, '0, 1, lat, nack, nerr, rdata, nbad);
    chk_int("ro_rd1_lat", lat, 1);
    chk_int("ro_rd1_acks", nack, 1);
    chk("ro_rd1_unchanged", rdata, ro_before);
    chk_int("ro_bad", nbad, 0);

    // Async reset between edges: during the ACK cycle of u_ws1 and mid-WAIT of u_ws3
    we = 1'b0; adr = 32'h10; sel = 16'hFFFF; dat_w = '0;
    set_req(0, 1'b1);
    set_req(3, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_ack", {127'd0, ack0}, 128'd1);
    chk("pre_rst_data", do0, D_A);
    #2 rst = 1'b1;
    #1;
    chk("rst_flags", {124'd0, ack0, err0, ack3, err3}, '0);
    chk("rst_data", do0 | do3, '0);
    set_req(0, 1'b0);
    set_req(3, 1'b0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    xfer(3, 1'b0, 32'h40, 16'hFFFF, '0, 1, lat, nack, nerr, rdata, nbad);
    chk_int("post_rst_ws3_lat", lat, 4);
    chk("post_rst_ws3_data", rdata, D_B);
    xfer(0, 1'b0, 32'h10, 16'hFFFF, '0, 1, lat, nack, nerr, rdata, nbad);
    chk_int("post_rst_ws1_lat", lat, 2);
    chk("post_rst_ws1_data", rdata, D_A);
    chk_int("post_rst_bad", nbad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/any1_wb_mem_responder.md
Name: any1_wb_mem_responder

Overview:
- Bus responder (slave) for the any1oo CPU's 128-bit bus: cyc/stb/ack/we/sel/adr/dat.
- Decodes one address window and backs it with a 128-bit-wide RAM that has per-byte write enables.
- Inserts a programmable number of wait states and flags out-of-window accesses with err_o.
- Used as system RAM in SoC builds and as the synthesizable memory model in CPU benches.

Parameters:
- ADDR_BASE, 32'h0000_0000, window base address; must be aligned to the window size.
- ADDR_MASK, 32'hFFFF_E000, compare mask for address decode (default gives an 8 KB window).
- DEPTH, 512, number of 128-bit words; power of two; DEPTH*16 must equal the window size.
- WAIT_STATES, 1, extra cycles between strobe sample and ack (0..15).
- READONLY, 0, 1 = writes are rejected with err_o.

Ports:
- rst_i  in  1  asynchronous active-high reset
- clk_i  in  1  clock
- cyc_i  in  1  bus cycle active
- stb_i  in  1  transfer strobe
- we_i  in  1  1 = write
- sel_i  in  16  byte-lane enables; bit n selects dat bits [8n+7:8n]
- adr_i  in  32  byte address; bits [3:0] ignored
- dat_i  in  128  write data
- ack_o  out  1  transfer complete
- err_o  out  1  transfer error (decode miss or write to READONLY)
- dat_o  out  128  read data

Behaviour:
- Reset: clk_i is the only clock; rst_i is asynchronous and active-high.
  - While rst_i is high: state=IDLE, ack_o=0, err_o=0, dat_o=0, wait counter=0.
  - Memory contents are not cleared.
  - Reset mid-transfer aborts it with no ack; a write is never partially applied, because commit happens on a single edge.
- Decode:
  - hit = ((adr_i & ADDR_MASK) == ADDR_BASE).
  - Word index = adr_i[4 +: log2(DEPTH)].
- FSM states: IDLE, WAIT, ACK, ERR, RELEASE.
- IDLE, when cyc_i & stb_i is sampled high:
  - If !hit, or (we_i & READONLY): go to ERR.
  - Else if WAIT_STATES==0: go to ACK.
  - Else: load counter with WAIT_STATES-1 and go to WAIT.
- WAIT:
  - If !cyc_i | !stb_i: go to IDLE (abort; no write, no ack).
  - Else if counter==0: go to ACK.
  - Else: decrement counter.
- Commit on entry to ACK:
  - Write: for each n with sel_i[n]=1, mem[idx] byte n <= dat_i byte n. sel_i=0 still acks and changes nothing.
  - Read: dat_o <= mem[idx] (all 16 bytes, regardless of sel_i).
  - adr_i, we_i, sel_i and dat_i are sampled at this edge; the master must hold them stable until ack.
- ACK:
  - ack_o=1 for exactly one cycle; dat_o is valid that cycle.
  - Next cycle dat_o returns to 0; go to RELEASE.
- ERR: err_o=1 for exactly one cycle; dat_o=0; go to RELEASE.
- RELEASE:
  - Stay while cyc_i & stb_i are high, so one strobe assertion yields exactly one response.
  - Go to IDLE when either drops.
- Latency:
  - ack_o is high in cycle S+WAIT_STATES+1, where S is the cycle in which stb is sampled.
  - err_o is high in cycle S+1.
- ack_o and err_o are never high together, and are never high outside ACK/ERR.
- Back-to-back transfers:
  - Minimum spacing is one idle cycle: stb must drop for at least one cycle between transfers.
  - Maximum throughput is one transfer per WAIT_STATES+3 cycles.
- Address wrap: none. Any address outside the window gives ERR, including ADDR_BASE+window size.

Test Plan:
- Full write then read, WAIT_STATES=1:
  - Write adr=0x10, sel=FFFF, dat=0x0011..EEFF, then read adr=0x10.
  - ack on the 2nd cycle after stb each time; dat_o=0x0011..EEFF during the ack cycle and 0 otherwise.
- Partial write:
  - Preload word 0x20 with all-ones, write sel=0x000F, dat=0, then read.
  - dat_o=0xFFFF..FFFF_0000_0000; a sel=0 write leaves the word unchanged and still acks.
- Decode miss:
  - Access adr=0xFF00_0000 with the default mask.
  - err_o high exactly one cycle after stb; ack_o never asserts; memory unchanged.
- Strobe held and abort:
  - Hold stb for 10 cycles: exactly one ack.
  - With WAIT_STATES=3, drop cyc in the 2nd wait cycle of a write: no ack, and a read-back shows the old data.
- READONLY=1 write:
  - err_o pulses and data is unchanged; reads to the same window still ack normally.
- Async reset mid-WAIT:
  - Assert rst_i between clock edges: ack_o/err_o/dat_o go to 0 immediately.
  - After release, the next transfer completes normally.
